// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/load-store arbiter for the shared byte-enabled RAM
// Optional starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_byte_we,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data_in,
  output logic              mem_we,
  output logic [3:0]        mem_byte_we,
  input  logic [31:0]       mem_data_out
);

  logic [6:0]  lane_span;
  logic        misaligned;
  logic        force_fetch;

  // Lanes touched after shifting into the word; anything past lane 3 crosses a word.
  assign lane_span  = {3'b000, d_byte_we} << d_addr[1:0];
  assign misaligned = (lane_span > 7'd15);

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt;

  assign force_fetch = (starve_cnt == 4'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (if_gnt || !if_req) begin
      starve_cnt <= 4'd0;
    end else if (d_gnt && !force_fetch) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  assign force_fetch = 1'b0;
`endif

  assign d_gnt  = !rst && d_req && !(if_req && force_fetch);
  assign if_gnt = !rst && if_req && !d_gnt;

  always_comb begin
    mem_address = if_addr;
    mem_data_in = d_wdata;
    mem_we      = 1'b0;
    mem_byte_we = 4'b0000;
    if (d_gnt) begin
      mem_address = d_addr;
      if (!misaligned) begin
        mem_we      = d_we;
        mem_byte_we = d_byte_we;
      end
    end
  end

  // Response tag: who owns the access in flight, plus the load size for masking.
  logic       tag_valid;
  logic       tag_data;
  logic       tag_err;
  logic [3:0] tag_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid <= 1'b0;
      tag_data  <= 1'b0;
      tag_err   <= 1'b0;
      tag_mask  <= 4'b0000;
    end else begin
      tag_valid <= if_gnt || (d_gnt && (!d_we || misaligned));
      tag_data  <= d_gnt;
      tag_err   <= d_gnt && misaligned;
      tag_mask  <= d_byte_we;
    end
  end

  logic [31:0] lane_mask;
  assign lane_mask = {{8{tag_mask[3]}}, {8{tag_mask[2]}}, {8{tag_mask[1]}}, {8{tag_mask[0]}}};

  // Gating with rst drops a response whose reset arrives while it is on the bus.
  assign if_rvalid = tag_valid && !tag_data && !rst;
  assign d_rvalid  = tag_valid && tag_data && !rst;
  assign d_err     = d_rvalid && tag_err;
  assign if_rdata  = if_rvalid ? mem_data_out : 32'h0;
  assign d_rdata   = (d_rvalid && !tag_err) ? (mem_data_out & lane_mask) : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with RAM wrapper model
module tb_mem_arbiter;

  localparam int LIMIT = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [13:0] if_addr;
  logic [31:0] if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [13:0] d_addr;
  logic [3:0]  d_byte_we;
  logic [31:0] d_wdata, d_rdata;
  logic [13:0] mem_address;
  logic [31:0] mem_data_in, mem_data_out;
  logic        mem_we;
  logic [3:0]  mem_byte_we;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(14), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_byte_we(d_byte_we), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_we(mem_we),
    .mem_byte_we(mem_byte_we), .mem_data_out(mem_data_out)
  );

  // RAM wrapper: byte lanes aligned to the address, read data shifted down, one-cycle latency.
  logic [7:0]  ram_b   [0:16383];
  logic [7:0]  ref_mem [0:16383];
  logic        pl_en = 1'b0;
  logic [13:0] pl_addr;
  logic [31:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) begin
      for (int i = 0; i < 4; i++) ram_b[pl_addr + 14'(i)] <= pl_data[8*i +: 8];
    end else if (mem_we) begin
      for (int i = 0; i < 4; i++)
        if (mem_byte_we[i]) ram_b[mem_address + 14'(i)] <= mem_data_in[8*i +: 8];
    end
    mem_data_out <= {ram_b[mem_address + 14'd3], ram_b[mem_address + 14'd2],
                     ram_b[mem_address + 14'd1], ram_b[mem_address]};
  end

  function automatic logic [31:0] ref_load(input logic [13:0] a, input logic [3:0] be);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < 4; i++) if (be[i]) v[8*i +: 8] = ref_mem[a + 14'(i)];
    return v;
  endfunction

  function automatic bit is_mis(input logic [13:0] a, input logic [3:0] be);
    int n = (be == 4'b0001) ? 1 : (be == 4'b0011) ? 2 : 4;
    return (int'(a[1:0]) + n) > 4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input logic [13:0] a, input logic [31:0] v);
    pl_en = 1'b1; pl_addr = a; pl_data = v;
    for (int i = 0; i < 4; i++) ref_mem[a + 14'(i)] = v[8*i +: 8];
    tick();
    pl_en = 1'b0;
  endtask

  task automatic idle();
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b1; if_addr = 14'h010;
    d_req = 1'b1; d_we = 1'b1; d_addr = 14'h020; d_byte_we = 4'b1111; d_wdata = 32'h12345678;
    tick();
    @(negedge clk);
    checks++; if (if_gnt !== 1'b0) begin errors++; $display("FAIL reset_if_gnt got %b exp 0", if_gnt); end
    checks++; if (d_gnt !== 1'b0) begin errors++; $display("FAIL reset_d_gnt got %b exp 0", d_gnt); end
    checks++; if (mem_we !== 1'b0 || mem_byte_we !== 4'b0) begin errors++; $display("FAIL reset_mem_we got %b/%b exp 0/0", mem_we, mem_byte_we); end
    checks++; if ({if_rvalid, d_rvalid, d_err} !== 3'b000) begin errors++; $display("FAIL reset_rvalid got %b exp 000", {if_rvalid, d_rvalid, d_err}); end
    checks++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h/%h exp 0", if_rdata, d_rdata); end
    tick();
    rst = 1'b0; idle();
    tick();
  endtask

  task automatic test_fetch_only();
    set_word(14'h010, 32'hDEADBEEF);
    if_req = 1'b1; if_addr = 14'h010;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (if_gnt !== 1'b1 || mem_address !== 14'h010) begin errors++; $display("FAIL fetch_gnt c%0d got %b @%h exp 1 @010", c, if_gnt, mem_address); end
      checks++; if (if_rvalid !== (c > 0)) begin errors++; $display("FAIL fetch_rvalid c%0d got %b exp %b", c, if_rvalid, c > 0); end
      if (c > 0) begin
        checks++; if (if_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_rdata c%0d got %h exp deadbeef", c, if_rdata); end
      end
      tick();
    end
    idle();
    @(negedge clk);
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_last got %b %h exp 1 deadbeef", if_rvalid, if_rdata); end
    tick();
  endtask

  task automatic test_collision();
    set_word(14'h020, 32'hCAFEF00D);
    set_word(14'h100, 32'h13579BDF);
    if_req = 1'b1; if_addr = 14'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 14'h020; d_byte_we = 4'b1111;
    @(negedge clk);
    checks++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin errors++; $display("FAIL coll_gnt got d%b i%b exp d1 i0", d_gnt, if_gnt); end
    checks++; if (mem_address !== 14'h020) begin errors++; $display("FAIL coll_addr got %h exp 020", mem_address); end
    tick();
    d_req = 1'b0;
    @(negedge clk);
    checks++; if (d_rvalid !== 1'b1 || if_rvalid !== 1'b0) begin errors++; $display("FAIL coll_rvalid got d%b i%b exp d1 i0", d_rvalid, if_rvalid); end
    checks++; if (d_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL coll_rdata got %h exp cafef00d", d_rdata); end
    checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL coll_fetch_after got %b exp 1", if_gnt); end
    tick();
    idle();
    @(negedge clk);
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h13579BDF) begin errors++; $display("FAIL coll_fetch_data got %b %h exp 1 13579bdf", if_rvalid, if_rdata); end
    tick();
  endtask

  task automatic test_starvation();
    rst = 1'b1; tick(); rst = 1'b0;
    if_req = 1'b1; if_addr = 14'h010;
    d_req = 1'b1; d_we = 1'b0; d_addr = 14'h020; d_byte_we = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      bit exp_f = GUARD && ((k % (LIMIT + 1)) == LIMIT);
      @(negedge clk);
      checks++; if (if_gnt !== exp_f || d_gnt !== !exp_f) begin errors++; $display("FAIL starve k%0d got i%b d%b exp i%b d%b", k, if_gnt, d_gnt, exp_f, !exp_f); end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_misaligned();
    set_word(14'h000, 32'hA1B2C3D4);
    d_req = 1'b1; d_we = 1'b1; d_addr = 14'h003; d_byte_we = 4'b1111; d_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    checks++; if (d_gnt !== 1'b1 || mem_we !== 1'b0 || mem_byte_we !== 4'b0) begin errors++; $display("FAIL mis_store got g%b we%b be%b exp g1 we0 be0", d_gnt, mem_we, mem_byte_we); end
    tick();
    d_addr = 14'h002; d_byte_we = 4'b0011; d_wdata = 32'h00005566;
    @(negedge clk);
    checks++; if (d_err !== 1'b1 || d_rvalid !== 1'b1 || d_rdata !== 32'h0) begin errors++; $display("FAIL mis_err got e%b v%b %h exp e1 v1 0", d_err, d_rvalid, d_rdata); end
    checks++; if (mem_we !== 1'b1 || mem_byte_we !== 4'b0011) begin errors++; $display("FAIL half_store got we%b be%b exp we1 be0011", mem_we, mem_byte_we); end
    ref_mem[14'h002] = 8'h66; ref_mem[14'h003] = 8'h55;
    tick();
    d_we = 1'b0; d_addr = 14'h000; d_byte_we = 4'b1111;
    @(negedge clk);
    checks++; if (d_rvalid !== 1'b0 || d_err !== 1'b0) begin errors++; $display("FAIL store_no_resp got v%b e%b exp v0 e0", d_rvalid, d_err); end
    tick();
    d_addr = 14'h003; d_byte_we = 4'b0011;
    @(negedge clk);
    checks++; if (d_rdata !== ref_load(14'h000, 4'hF)) begin errors++; $display("FAIL ram_after_mis got %h exp %h", d_rdata, ref_load(14'h000, 4'hF)); end
    tick();
    idle();
    @(negedge clk);
    checks++; if (d_err !== 1'b1 || d_rvalid !== 1'b1 || d_rdata !== 32'h0) begin errors++; $display("FAIL mis_load got e%b v%b %h exp e1 v1 0", d_err, d_rvalid, d_rdata); end
    tick();
  endtask

  task automatic test_byte_load();
    set_word(14'h040, 32'h11223344);
    d_req = 1'b1; d_we = 1'b0; d_addr = 14'h041; d_byte_we = 4'b0001;
    tick();
    d_addr = 14'h042; d_byte_we = 4'b0011;
    @(negedge clk);
    checks++; if (d_rdata !== 32'h00000033) begin errors++; $display("FAIL byte_load got %h exp 00000033", d_rdata); end
    tick();
    idle();
    @(negedge clk);
    checks++; if (d_rdata !== 32'h00001122) begin errors++; $display("FAIL half_load got %h exp 00001122", d_rdata); end
    tick();
  endtask

  task automatic test_reset_mid_read();
    if_req = 1'b1; if_addr = 14'h010;
    d_req = 1'b1; d_we = 1'b0; d_addr = 14'h040; d_byte_we = 4'b1111;
    for (int k = 0; k < 3; k++) tick();
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({d_rvalid, if_rvalid, d_err} !== 3'b000 || d_rdata !== 32'h0) begin errors++; $display("FAIL rst_mid_read got %b %h exp 000 0", {d_rvalid, if_rvalid, d_err}, d_rdata); end
    checks++; if ({if_gnt, d_gnt, mem_we} !== 3'b000) begin errors++; $display("FAIL rst_mid_gnt got %b exp 000", {if_gnt, d_gnt, mem_we}); end
    tick();
    rst = 1'b0;
    for (int k = 0; k < LIMIT + 1; k++) begin
      bit exp_f = GUARD && (k == LIMIT);
      @(negedge clk);
      checks++; if (if_gnt !== exp_f || d_gnt !== !exp_f) begin errors++; $display("FAIL rst_cnt k%0d got i%b d%b exp i%b d%b", k, if_gnt, d_gnt, exp_f, !exp_f); end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_random();
    int          cnt = 0;
    bit          pv = 1'b0, pd = 1'b0, pe = 1'b0;
    logic [31:0] pval = 32'h0;
    logic [3:0]  bes [3] = '{4'b0001, 4'b0011, 4'b1111};
    bit          f, eg_d, eg_i, mis;
    for (int w = 0; w < 16; w++) set_word(14'(w * 4), $urandom);
    for (int n = 0; n < 400; n++) begin
      if (!if_req) begin
        if_req = 1'($urandom);
        if_addr = 14'($urandom_range(0, 15) * 4);
      end
      if (!d_req) begin
        d_req = ($urandom_range(0, 3) != 0);
        d_we = 1'($urandom);
        d_addr = 14'($urandom_range(0, 63));
        d_byte_we = bes[$urandom_range(0, 2)];
        d_wdata = $urandom;
      end
      @(negedge clk);
      mis  = is_mis(d_addr, d_byte_we);
      f    = GUARD && if_req && d_req && (cnt == LIMIT);
      eg_d = d_req && !f;
      eg_i = if_req && !eg_d;
      checks++; if (if_gnt !== eg_i || d_gnt !== eg_d) begin errors++; $display("FAIL rnd_gnt n%0d got i%b d%b exp i%b d%b", n, if_gnt, d_gnt, eg_i, eg_d); end
      checks++; if (if_rvalid !== (pv && !pd) || d_rvalid !== (pv && pd) || d_err !== (pv && pd && pe)) begin
        errors++; $display("FAIL rnd_resp n%0d got i%b d%b e%b exp i%b d%b e%b", n, if_rvalid, d_rvalid, d_err, pv && !pd, pv && pd, pv && pd && pe);
      end
      checks++; if (if_rdata !== ((pv && !pd) ? pval : 32'h0) || d_rdata !== ((pv && pd) ? pval : 32'h0)) begin
        errors++; $display("FAIL rnd_rdata n%0d got i%h d%h exp %h", n, if_rdata, d_rdata, pval);
      end
      if (eg_d && d_we && !mis) begin
        checks++; if (mem_we !== 1'b1 || mem_byte_we !== d_byte_we) begin errors++; $display("FAIL rnd_store n%0d got we%b be%b exp we1 be%b", n, mem_we, mem_byte_we, d_byte_we); end
      end
      if (GUARD) begin
        if (eg_i || !if_req) cnt = 0;
        else if (eg_d && cnt < LIMIT) cnt++;
      end
      pv   = eg_i || (eg_d && (!d_we || mis));
      pd   = eg_d;
      pe   = eg_d && mis;
      pval = eg_i ? ref_load(if_addr, 4'hF) : (mis ? 32'h0 : ref_load(d_addr, d_byte_we));
      if (eg_d && d_we && !mis)
        for (int i = 0; i < 4; i++) if (d_byte_we[i]) ref_mem[d_addr + 14'(i)] = d_wdata[8*i +: 8];
      tick();
      if (eg_i) if_req = 1'b0;
      if (eg_d) d_req = 1'b0;
    end
    idle();
    tick();
  endtask

  initial begin
    rst = 1'b1; idle();
    if_addr = 14'h0; d_addr = 14'h0; d_byte_we = 4'b0; d_wdata = 32'h0;
    pl_addr = 14'h0; pl_data = 32'h0;
    tick();
    test_reset();
    test_fetch_only();
    test_collision();
    test_starvation();
    test_misaligned();
    test_byte_load();
    test_reset_mid_read();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
